// File: rtl/uart_rx_cfg_if.sv
// Receive-word handshake between the UART receiver and its consumer.
// The receiver drives the held word and its per-word error flags; the consumer drives ready.
interface uart_rx_cfg_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 parity_err;
    logic                 frame_err;

    modport master (
        output rx_data,
        output rx_valid,
        output parity_err,
        output frame_err,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  parity_err,
        input  frame_err,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_cfg.sv
// Parametrised oversampling UART receiver with 3-sample majority voting,
// a ready/valid holding register carrying per-word error flags, and break detection.
module uart_rx_cfg #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rxd,
    uart_rx_cfg_if.master rx,
    output logic          overrun,
    output logic          break_det,
    output logic          busy
);

    localparam int DIV    = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int DIV_W  = $clog2(DIV + 1);
    localparam int TICK_W = $clog2(OVERSAMPLE);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);
    localparam logic [DIV_W-1:0]  DIV_ZERO  = DIV_W'(0);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
    localparam logic [TICK_W-1:0] TICK_ZERO = TICK_W'(0);
    localparam logic [TICK_W-1:0] SAMP_A    = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] SAMP_B    = TICK_W'(OVERSAMPLE / 2);
    localparam logic [TICK_W-1:0] SAMP_C    = TICK_W'(OVERSAMPLE / 2 + 1);
    localparam logic [3:0]        DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]        STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic              HAS_PAR   = (PARITY != 0) ? 1'b1 : 1'b0;
    localparam logic              ODD_PAR   = (PARITY == 2) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_DATA     = 3'd2,
        ST_PARITY   = 3'd3,
        ST_STOP     = 3'd4,
        ST_BRK_WAIT = 3'd5
    } state_t;

    function automatic logic maj3_f(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic par_err_f(input logic [DATA_BITS-1:0] d, input logic p);
        return HAS_PAR & ((^d) ^ p ^ ODD_PAR);
    endfunction

    logic                 rxd_meta_r;
    logic                 rxs_r;
    logic [DIV_W-1:0]     div_cnt_r;
    logic [TICK_W-1:0]    tick_cnt_r;
    state_t               state_r;
    logic [3:0]           bit_cnt_r;
    logic [1:0]           samp_r;
    logic [DATA_BITS-1:0] shift_r;
    logic                 par_bit_r;
    logic                 stop_err_r;
    logic [DATA_BITS-1:0] data_r;
    logic                 valid_r;
    logic                 perr_r;
    logic                 ferr_r;
    logic                 overrun_r;
    logic                 break_r;
    logic                 busy_r;

    logic                 start_det_s;
    logic                 tick_s;
    logic [TICK_W-1:0]    tick_idx_s;
    logic                 vote_en_s;
    logic                 bound_s;
    logic                 vote_s;
    logic                 consume_s;
    logic                 break_s;

    assign rx.rx_data    = data_r;
    assign rx.rx_valid   = valid_r;
    assign rx.parity_err = perr_r;
    assign rx.frame_err  = ferr_r;
    assign overrun       = overrun_r;
    assign break_det     = break_r;
    assign busy          = busy_r;

    // Tick index of the tick currently firing; index 0 marks a bit boundary.
    always_comb begin
        tick_idx_s = TICK_ZERO;
        if (tick_cnt_r == TICK_LAST) begin
            tick_idx_s = TICK_ZERO;
        end else begin
            tick_idx_s = tick_cnt_r + TICK_ONE;
        end
    end

    assign start_det_s = (state_r == ST_IDLE) && !rxs_r;
    assign tick_s      = (div_cnt_r == DIV_LAST);
    assign vote_en_s   = tick_s && (tick_idx_s == SAMP_C);
    assign bound_s     = tick_s && (tick_idx_s == TICK_ZERO);
    assign vote_s      = maj3_f(samp_r[0], samp_r[1], rxs_r);
    assign consume_s   = valid_r && rx.rx_ready;
    // A line held low through data, parity and the first stop bit is a break, not a word.
    assign break_s     = (shift_r == {DATA_BITS{1'b0}}) && !(HAS_PAR & par_bit_r) && !vote_s;

    // Two-flop synchroniser for the asynchronous serial line, idling high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxd_meta_r <= 1'b1;
            rxs_r      <= 1'b1;
        end else begin
            rxd_meta_r <= rxd;
            rxs_r      <= rxd_meta_r;
        end
    end

    // Sample-tick divider and tick-within-bit counter, realigned to each start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt_r  <= DIV_ZERO;
            tick_cnt_r <= TICK_ZERO;
        end else if (start_det_s) begin
            div_cnt_r  <= DIV_ZERO;
            tick_cnt_r <= TICK_ZERO;
        end else if (tick_s) begin
            div_cnt_r  <= DIV_ZERO;
            tick_cnt_r <= tick_idx_s;
        end else begin
            div_cnt_r  <= div_cnt_r + DIV_ONE;
        end
    end

    // Frame FSM together with the holding register and its one-cycle status pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            bit_cnt_r  <= 4'd0;
            samp_r     <= 2'b00;
            shift_r    <= {DATA_BITS{1'b0}};
            par_bit_r  <= 1'b0;
            stop_err_r <= 1'b0;
            data_r     <= {DATA_BITS{1'b0}};
            valid_r    <= 1'b0;
            perr_r     <= 1'b0;
            ferr_r     <= 1'b0;
            overrun_r  <= 1'b0;
            break_r    <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            overrun_r <= 1'b0;
            break_r   <= 1'b0;
            if (consume_s) begin
                valid_r <= 1'b0;
            end
            if (tick_s && (tick_idx_s == SAMP_A)) begin
                samp_r[0] <= rxs_r;
            end
            if (tick_s && (tick_idx_s == SAMP_B)) begin
                samp_r[1] <= rxs_r;
            end

            case (state_r)
                ST_IDLE: begin
                    if (!rxs_r) begin
                        state_r    <= ST_START;
                        busy_r     <= 1'b1;
                        bit_cnt_r  <= 4'd0;
                        par_bit_r  <= 1'b0;
                        stop_err_r <= 1'b0;
                    end
                end
                ST_START: begin
                    if (vote_en_s && vote_s) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else if (bound_s) begin
                        state_r   <= ST_DATA;
                        bit_cnt_r <= 4'd0;
                    end
                end
                ST_DATA: begin
                    if (vote_en_s) begin
                        shift_r <= {vote_s, shift_r[DATA_BITS-1:1]};
                        if (bit_cnt_r == DATA_LAST) begin
                            bit_cnt_r <= 4'd0;
                            state_r   <= HAS_PAR ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (vote_en_s) begin
                        par_bit_r <= vote_s;
                        state_r   <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (vote_en_s) begin
                        if ((bit_cnt_r == 4'd0) && break_s) begin
                            break_r <= 1'b1;
                            state_r <= ST_BRK_WAIT;
                        end else if (bit_cnt_r == STOP_LAST) begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                            // A word completing against an unread one is dropped; the held word stays intact.
                            if (valid_r && !rx.rx_ready) begin
                                overrun_r <= 1'b1;
                            end else begin
                                data_r  <= shift_r;
                                perr_r  <= par_err_f(shift_r, par_bit_r);
                                ferr_r  <= stop_err_r | !vote_s;
                                valid_r <= 1'b1;
                            end
                        end else begin
                            stop_err_r <= stop_err_r | !vote_s;
                            bit_cnt_r  <= bit_cnt_r + 4'd1;
                        end
                    end
                end
                ST_BRK_WAIT: begin
                    if (rxs_r) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised UART receiver for the sensor-link serial input. It accepts asynchronous serial frames with configurable data width, parity and stop bits, and uses 3-sample majority voting at an oversampled rate. Each received word is presented on a ready/valid holding register that carries per-word error flags. It sits between the board `rxd` pin and the command/telemetry parser, replacing the fixed 8N1 9600-baud receiver.

## Interface
- `CLK_HZ`, 50000000: system clock frequency in Hz.
- `BAUD`, 9600: line bit rate.
- `OVERSAMPLE`, 16: sample ticks per bit; even, ≥8.
- `DATA_BITS`, 8: data bits per frame, 5..8.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: 1 or 2.
- `clk` input 1: system clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `rxd` input 1: asynchronous serial line, idle high.
- `rx_data` output DATA_BITS: received word, LSB = first bit on the line.
- `rx_valid` output 1: holding register full.
- `rx_ready` input 1: consumer accepts the word when `rx_valid && rx_ready`.
- `parity_err` output 1: parity mismatch on the held word; meaningful only while `rx_valid`.
- `frame_err` output 1: a stop bit sampled 0 on the held word; meaningful only while `rx_valid`.
- `overrun` output 1: one-cycle pulse when a completed word is dropped.
- `break_det` output 1: one-cycle pulse on line-break detection.
- `busy` output 1: high whenever the FSM is not IDLE.

## Operation
- **Reset:** all outputs are 0 and `rx_data` is 0. FSM is in IDLE, counters are 0, and both synchroniser flops are 1.
- **Input synchroniser:** `rxd` passes through a 2-flop synchroniser (`rxs`). All logic uses `rxs` only.
- **Sample tick:** a tick fires every `DIV = CLK_HZ/(BAUD*OVERSAMPLE)` clocks (integer truncation). The tick divider and the tick counter restart on start detection.
- **Majority vote:** each bit is resolved by majority of `rxs` at ticks `OVERSAMPLE/2-1`, `OVERSAMPLE/2` and `OVERSAMPLE/2+1` within that bit.
- **FSM states and transitions:**
  - IDLE → START when `rxs == 0`.
  - START: if the vote is 1, it is a false start; return to IDLE with no flags. Otherwise go to DATA at the bit boundary.
  - DATA: `DATA_BITS` bits, shifted in LSB first.
  - PARITY: present only if `PARITY != 0`. The computed error is XOR of data bits and parity bit, XORed with 1 for odd parity.
  - STOP: `STOP_BITS` bits. Any stop vote of 0 sets `frame_err`.
- **Word completion:** occurs at the vote of the last stop bit. The FSM returns to IDLE immediately, so a following start edge is detected without waiting for the end of the stop bit.
- **Break:** if every data bit, the parity bit and the first stop bit all vote 0, there is no write. `break_det` pulses and the FSM enters BRK_WAIT. It leaves BRK_WAIT for IDLE only after `rxs == 1`.
- **Holding register:** on completion, `rx_data`, `parity_err` and `frame_err` are loaded together and `rx_valid` is set.
  - Consume: `rx_valid && rx_ready` clears `rx_valid` next cycle.
  - Completion while `rx_valid && !rx_ready`: the new word is discarded, `overrun` pulses, and the held word and its flags are unchanged.
  - Completion in the same cycle as a consume: the new word loads, `rx_valid` stays 1, and there is no overrun.
- **Reset mid-frame:** the partial frame is discarded and the block returns to the reset state immediately (asynchronous).

## Timing
- Synchroniser latency is 2 clocks. Start detection takes 1 further clock.
- `rx_valid` rises `(1 + DATA_BITS + P + STOP_BITS − 0.5) × OVERSAMPLE × DIV` clocks after the `rxd` falling edge, within ±(DIV+4) clocks. P = 1 if parity is enabled, else 0.
- `overrun` and `break_det` are high for exactly 1 clock. `busy` falls in the same cycle `rx_valid` rises.
- Tolerated baud mismatch: ±3% for 8N1 with `OVERSAMPLE` = 16.

## Test plan
Bench parameters: `CLK_HZ`=1600000, `BAUD`=10000, `OVERSAMPLE`=16, so DIV=10 and one bit = 160 clocks.
- 8N1, send 0xA5, `rx_ready`=1 → `rx_valid` for 1 clock at 1520±14 clocks, `rx_data`=0xA5, both error flags 0.
- 7E2, send 0x35 with parity bit inverted → `rx_data`=0x35, `parity_err`=1, `frame_err`=0. Resend with correct parity → both error flags 0.
- 8N1, send 0x3C with stop bit 0 → `rx_data`=0x3C, `frame_err`=1. Then a 0xFF frame with a valid stop → `frame_err`=0.
- 40-clock low glitch on `rxd` → no `rx_valid`, `busy` returns to 0 within 100 clocks. A following 0x5A frame is received correctly.
- `rx_ready`=0, send 0x11 then 0x22 → `rx_valid` with 0x11. At 0x22 completion: `overrun` pulses once and `rx_data` stays 0x11. Raise `rx_ready` → `rx_valid` clears and no further word appears.
- Line low for 12 bit times → exactly one `break_det` pulse and no `rx_valid`. Release the line, then send 0x5A → correct receipt. Assert `rst` mid-frame → all outputs 0 and the next frame is received cleanly.
